// File: rtl/alu_ctrl_fsm.sv
// Multicycle control FSM: sequences ALU muxes/op and datapath strobes for fetch, decode, R-type, addi, lw, sw, beq, j.
// Optional macro ADDM_EN adds addm (rd <- Mem[RegA+imm] + RegB) via an extra ADDM_EX state.
module alu_ctrl_fsm #(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [1:0] alusrca_sel,
    output logic [1:0] alusrcb_sel,
    output logic [2:0] alu_op,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_wr,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state_out
);
    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_ADDR    = 4'd5,
        S_WB_I    = 4'd6,
        S_MEM_RD  = 4'd7,
        S_WB_LW   = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ADDM_EX = 4'd12,
        S_TRAP    = 4'd15
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDM  = 6'h01;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_last;
    logic       w_funct_ok;
    logic       w_addm;

    assign w_last     = (r_cnt == LAST_CNT);
    assign w_funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
`ifdef ADDM_EN
    assign w_addm = (opcode == OPC_ADDM);
`else
    assign w_addm = 1'b0;
`endif
    assign state_out = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RST;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        alusrca_sel  = 2'b00;
        alusrcb_sel  = 2'b00;
        alu_op       = 3'b000;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        ir_write     = 1'b0;
        iord         = 1'b0;
        mem_wr       = 1'b0;
        mdr_write    = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        case (r_state)
            S_RST: w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_last) begin
                    ir_write    = 1'b1;
                    alusrca_sel = 2'b10;
                    alusrcb_sel = 2'b01;
                    alu_op      = OP_ADD;
                    pc_write    = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures the branch target while the opcode is dispatched
                ab_write     = 1'b1;
                alusrca_sel  = 2'b10;
                alusrcb_sel  = 2'b11;
                alu_op       = OP_ADD;
                aluout_write = 1'b1;
                if (opcode == OPC_RTYPE)
                    w_state_nxt = w_funct_ok ? S_EXEC_R : S_TRAP;
                else if ((opcode == OPC_ADDI) || (opcode == OPC_LW) || (opcode == OPC_SW) || w_addm)
                    w_state_nxt = S_ADDR;
                else if (opcode == OPC_BEQ)
                    w_state_nxt = S_BRANCH;
                else if (opcode == OPC_J)
                    w_state_nxt = S_JUMP;
                else
                    w_state_nxt = S_TRAP;
            end
            S_EXEC_R: begin
                alusrca_sel  = 2'b01;
                aluout_write = 1'b1;
                case (funct)
                    FN_SUB:  alu_op = OP_SUB;
                    FN_AND:  alu_op = OP_AND;
                    default: alu_op = OP_ADD;
                endcase
                w_state_nxt = S_WB_R;
            end
            S_WB_R: begin
                reg_write   = 1'b1;
                reg_dst     = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_ADDR: begin
                alusrca_sel  = 2'b01;
                alusrcb_sel  = 2'b10;
                alu_op       = OP_ADD;
                aluout_write = 1'b1;
                if (opcode == OPC_ADDI)
                    w_state_nxt = S_WB_I;
                else if (opcode == OPC_SW)
                    w_state_nxt = S_MEM_WR;
                else
                    w_state_nxt = S_MEM_RD;
            end
            S_WB_I: begin
                reg_write   = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_MEM_RD: begin
                iord = 1'b1;
                if (w_last) begin
                    mdr_write   = 1'b1;
                    w_state_nxt = w_addm ? S_ADDM_EX : S_WB_LW;
                end
            end
            S_WB_LW: begin
                reg_write   = 1'b1;
                mem_to_reg  = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_MEM_WR: begin
                iord        = 1'b1;
                mem_wr      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_sel = 2'b01;
                alu_op      = OP_SUB;
                pc_src      = 2'b01;
                pc_write    = zero;
                w_state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_src      = 2'b10;
                pc_write    = 1'b1;
                w_state_nxt = S_FETCH;
            end
`ifdef ADDM_EN
            S_ADDM_EX: begin
                alusrca_sel  = 2'b11;
                alu_op       = OP_ADD;
                aluout_write = 1'b1;
                w_state_nxt  = S_WB_R;
            end
`endif
            S_TRAP: illegal = 1'b1;
            default: w_state_nxt = S_TRAP;
        endcase

        // Counter restarts on every state change, so it is 0 on entry to FETCH/MEM_RD; saturates instead of wrapping
        if (w_state_nxt != r_state)
            w_cnt_nxt = 4'd0;
        else if (r_cnt != 4'hF)
            w_cnt_nxt = r_cnt + 4'd1;
        else
            w_cnt_nxt = r_cnt;
    end
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Scoreboarded random/directed bench for alu_ctrl_fsm: an instruction-level model queues the expected
// per-cycle output vector; a negedge monitor pops and compares every cycle.
module tb_alu_ctrl_fsm;
    localparam int M = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [1:0] alusrca_sel;
    logic [1:0] alusrcb_sel;
    logic [2:0] alu_op;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_wr;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state_out;

    alu_ctrl_fsm #(.MEM_LAT(M)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alusrca_sel(alusrca_sel), .alusrcb_sel(alusrcb_sel), .alu_op(alu_op),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_wr(mem_wr), .mdr_write(mdr_write), .ab_write(ab_write),
        .aluout_write(aluout_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] op;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       iord;
        logic       memwr;
        logic       mdrw;
        logic       abw;
        logic       aluw;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic       ill;
    } exp_t;

    localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ADDM = 6, K_TRAP = 7;

    exp_t exp_q[$];
    exp_t seq_q[$];
    exp_t dut_v;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   end_req = 1'b0;
    bit   mon_done = 1'b0;
    bit   last_trap;

    assign dut_v = {state_out, alusrca_sel, alusrcb_sel, alu_op, pc_write, pc_src, ir_write, iord,
                    mem_wr, mdr_write, ab_write, aluout_write, reg_write, reg_dst, mem_to_reg, illegal};

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (end_req) begin
            if (!mon_done) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: %0d expected cycles never observed, required 0", exp_q.size());
                end
                mon_done = 1'b1;
            end
        end else if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL underrun at cycle %0d: DUT state %0d with no expectation queued", cyc, state_out);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_v !== e) begin
                n_bad++;
                $display("FAIL outputs at cycle %0d: got %h (state %0d) required %h (state %0d)",
                         cyc, dut_v, dut_v.st, e, e.st);
            end
        end
    end

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) ? K_R : K_TRAP;
        case (op)
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
`ifdef ADDM_EN
            6'h01: return K_ADDM;
`endif
            default: return K_TRAP;
        endcase
    endfunction

    task automatic add_mem_read();
        exp_t e;
        for (int i = 0; i < M; i++) begin
            e = blank(4'd7);
            e.iord = 1'b1;
            e.mdrw = (i == M - 1);
            seq_q.push_back(e);
        end
    endtask

    task automatic add_addr();
        exp_t e;
        e = blank(4'd5); e.srca = 2'b01; e.srcb = 2'b10; e.op = 3'b001; e.aluw = 1'b1;
        seq_q.push_back(e);
    endtask

    task automatic add_wb_r();
        exp_t e;
        e = blank(4'd4); e.regw = 1'b1; e.regdst = 1'b1;
        seq_q.push_back(e);
    endtask

    // Whole-instruction expected cycle sequence, built from the per-instruction step list
    task automatic model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        exp_t e;
        int   k;
        seq_q.delete();
        for (int i = 0; i < M; i++) begin
            e = blank(4'd1);
            if (i == M - 1) begin
                e.irw = 1'b1; e.srca = 2'b10; e.srcb = 2'b01; e.op = 3'b001; e.pcw = 1'b1;
            end
            seq_q.push_back(e);
        end
        e = blank(4'd2); e.abw = 1'b1; e.srca = 2'b10; e.srcb = 2'b11; e.op = 3'b001; e.aluw = 1'b1;
        seq_q.push_back(e);
        k = classify(op, fn);
        last_trap = (k == K_TRAP);
        case (k)
            K_R: begin
                e = blank(4'd3); e.srca = 2'b01; e.aluw = 1'b1;
                e.op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
                seq_q.push_back(e);
                add_wb_r();
            end
            K_ADDI: begin
                add_addr();
                e = blank(4'd6); e.regw = 1'b1; seq_q.push_back(e);
            end
            K_LW: begin
                add_addr();
                add_mem_read();
                e = blank(4'd8); e.regw = 1'b1; e.m2r = 1'b1; seq_q.push_back(e);
            end
            K_SW: begin
                add_addr();
                e = blank(4'd9); e.iord = 1'b1; e.memwr = 1'b1; seq_q.push_back(e);
            end
            K_BEQ: begin
                e = blank(4'd10); e.srca = 2'b01; e.op = 3'b010; e.pcs = 2'b01; e.pcw = z;
                seq_q.push_back(e);
            end
            K_J: begin
                e = blank(4'd11); e.pcs = 2'b10; e.pcw = 1'b1; seq_q.push_back(e);
            end
            K_ADDM: begin
                add_addr();
                add_mem_read();
                e = blank(4'd12); e.srca = 2'b11; e.op = 3'b001; e.aluw = 1'b1; seq_q.push_back(e);
                add_wb_r();
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    e = blank(4'd15); e.ill = 1'b1; seq_q.push_back(e);
                end
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(blank(4'd0));
            cycle();
        end
        reset = 1'b0;
        exp_q.push_back(blank(4'd0));
        cycle();
    endtask

    // Called at the start of a FETCH cycle; abort_at < 0 runs the whole instruction
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input int abort_at);
        int n;
        opcode = op;
        funct  = fn;
        zero   = z;
        model(op, fn, z);
        n = seq_q.size();
        if (abort_at >= 0 && abort_at < n) n = abort_at;
        for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
        repeat (n) cycle();
        if (abort_at >= 0 || last_trap) do_reset(2);
    endtask

    initial begin
        logic [5:0] pool [7];
        logic [5:0] op;
        logic [5:0] fn;
        pool = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h01};
        reset  = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        zero   = 1'b0;
        cycle();
        do_reset(2);

        run_instr(6'h00, 6'h20, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, -1);
        run_instr(6'h04, 6'h11, 1'b1, -1);
        run_instr(6'h04, 6'h11, 1'b0, -1);
        run_instr(6'h2B, 6'h3F, 1'b1, -1);
        run_instr(6'h08, 6'h00, 1'b0, -1);
        run_instr(6'h02, 6'h00, 1'b0, -1);
        run_instr(6'h00, 6'h22, 1'b0, -1);
        run_instr(6'h00, 6'h24, 1'b1, -1);
        run_instr(6'h01, 6'h20, 1'b0, -1);
        run_instr(6'h00, 6'h25, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, M + 2);
        run_instr(6'h00, 6'h20, 1'b0, -1);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
            else op = pool[$urandom_range(0, 6)];
            case ($urandom_range(0, 3))
                0: fn = 6'h20;
                1: fn = 6'h22;
                2: fn = 6'h24;
                default: fn = 6'($urandom_range(0, 63));
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 15) == 0) ? $urandom_range(1, 2 * M + 3) : -1);
        end

        end_req = 1'b1;
        fork
            wait (mon_done);
            repeat (10) @(posedge clk);
        join_any
        disable fork;
        if (!mon_done) begin
            $display("FAIL monitor: final drain not reached within 10 cycles, required completion");
            $fatal(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
